// File: rtl/uart_autobaud_rx.sv
// -----------------------------------------------------------------------------
// uart_autobaud_rx
//
// 8N1 UART receiver that measures its own bit period from a 0x55 calibration
// character. The low start bit of 0x55 is timed in clk cycles. That count
// becomes the divider. The rest of the calibration character is skipped, and
// normal reception then samples each bit at its centre.
//
// Ports
//   clk          in   rising-edge clock, the only clock domain
//   nRst         in   asynchronous active-low reset
//   rx           in   asynchronous serial line, idle high, LSB first
//   relock       in   one-cycle request to drop the divider and recalibrate
//   recieved     out  one-cycle pulse per good frame, aligned with data_rx
//   data_rx      out  last good byte, held until the next good frame
//   busy_rx      out  high while skipping the calibration byte or in a frame
//   framing_err  out  one-cycle pulse when a stop bit samples low
//   baud_locked  out  high while a valid divider is held
//   baud_div     out  measured bit period in clk cycles
// -----------------------------------------------------------------------------
module uart_autobaud_rx #(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             rx,
    input  logic             relock,
    output logic             recieved,
    output logic [7:0]       data_rx,
    output logic             busy_rx,
    output logic             framing_err,
    output logic             baud_locked,
    output logic [DIV_W-1:0] baud_div
);

    // The counter is wider than the divider. This lets the calibration skip
    // count (8.5 bit periods) share the same register.
    localparam int CW = DIV_W + 4;
    localparam logic [CW-1:0] MIN_DIV_C = CW'(MIN_DIV);

    localparam logic [2:0] CAL_IDLE    = 3'd0;
    localparam logic [2:0] CAL_MEASURE = 3'd1;
    localparam logic [2:0] CAL_SKIP    = 3'd2;
    localparam logic [2:0] IDLE        = 3'd3;
    localparam logic [2:0] START       = 3'd4;
    localparam logic [2:0] DATA        = 3'd5;
    localparam logic [2:0] STOP        = 3'd6;

    logic [1:0]       sync_q;
    logic             rx_s;
    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             locked_q, locked_d;
    logic             rcv_q, rcv_d;
    logic             ferr_q, ferr_d;
    logic             wait_high_q, wait_high_d;

    logic [CW-1:0]    div_ext;
    logic [CW-1:0]    half_div;
    logic [CW-1:0]    skip_target;

    // Two-flop synchronizer. The flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    assign div_ext     = {4'b0000, div_q};
    assign half_div    = div_ext >> 1;
    // Calibration starts at the first high bit after the start bit. After
    // 8.5 bit periods the receiver sits in the middle of the high stop bit.
    assign skip_target = (div_ext << 3) + half_div;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        div_d       = div_q;
        locked_d    = locked_q;
        rcv_d       = 1'b0;
        ferr_d      = 1'b0;
        wait_high_d = wait_high_q;

        if (relock) begin
            // Abort silently. The old divider stays visible until a new
            // divider is latched.
            state_d     = CAL_IDLE;
            locked_d    = 1'b0;
            count_d     = '0;
            bit_idx_d   = '0;
            wait_high_d = 1'b0;
        end else begin
            case (state_q)
                CAL_IDLE: begin
                    if (!rx_s) begin
                        state_d = CAL_MEASURE;
                        count_d = CW'(1);
                    end
                end
                CAL_MEASURE: begin
                    if (!rx_s) begin
                        if (count_q[DIV_W-1:0] == {DIV_W{1'b1}}) begin
                            // Line stuck low: give up without touching the divider.
                            state_d = CAL_IDLE;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end else if (count_q < MIN_DIV_C) begin
                        // Too short to be a real start bit.
                        state_d = CAL_IDLE;
                        count_d = '0;
                    end else begin
                        div_d    = count_q[DIV_W-1:0];
                        locked_d = 1'b1;
                        state_d  = CAL_SKIP;
                        count_d  = CW'(1);
                    end
                end
                CAL_SKIP: begin
                    if (count_q >= skip_target) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                IDLE: begin
                    if (wait_high_q) begin
                        // After a framing error the line must return high
                        // before a new start bit is accepted.
                        if (rx_s) begin
                            wait_high_d = 1'b0;
                        end
                    end else if (!rx_s) begin
                        state_d = START;
                        count_d = CW'(1);
                    end
                end
                START: begin
                    if (count_q >= half_div) begin
                        if (!rx_s) begin
                            state_d   = DATA;
                            count_d   = CW'(1);
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                DATA: begin
                    if (count_q >= div_ext) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        count_d = CW'(1);
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                STOP: begin
                    if (count_q >= div_ext) begin
                        if (rx_s) begin
                            data_d = shift_q;
                            rcv_d  = 1'b1;
                        end else begin
                            ferr_d      = 1'b1;
                            wait_high_d = 1'b1;
                        end
                        // Back to IDLE straight away, so a start bit that
                        // follows directly is still caught.
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                default: begin
                    state_d = CAL_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= CAL_IDLE;
            count_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            div_q       <= '0;
            locked_q    <= 1'b0;
            rcv_q       <= 1'b0;
            ferr_q      <= 1'b0;
            wait_high_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            div_q       <= div_d;
            locked_q    <= locked_d;
            rcv_q       <= rcv_d;
            ferr_q      <= ferr_d;
            wait_high_q <= wait_high_d;
        end
    end

    assign recieved    = rcv_q;
    assign framing_err = ferr_q;
    assign data_rx     = data_q;
    assign baud_locked = locked_q;
    assign baud_div    = div_q;
    assign busy_rx     = (state_q == CAL_SKIP) || (state_q == START) ||
                         (state_q == DATA)     || (state_q == STOP);

endmodule

// File: tb/tb_uart_autobaud_rx.sv
module tb_uart_autobaud_rx;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic             rx = 1'b1;
    logic             relock = 1'b0;
    logic             recieved;
    logic [7:0]       data_rx;
    logic             busy_rx;
    logic             framing_err;
    logic             baud_locked;
    logic [DIV_W-1:0] baud_div;

    uart_autobaud_rx #(.DIV_W(DIV_W), .MIN_DIV(8)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .rx          (rx),
        .relock      (relock),
        .recieved    (recieved),
        .data_rx     (data_rx),
        .busy_rx     (busy_rx),
        .framing_err (framing_err),
        .baud_locked (baud_locked),
        .baud_div    (baud_div)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rcv_cnt = 0;
    int ferr_cnt = 0;
    int overlap_cnt = 0;

    // Count the output pulses, one count per cycle in which each is high.
    always @(negedge clk) begin
        if (recieved)    rcv_cnt++;
        if (framing_err) ferr_cnt++;
        if (recieved && framing_err) overlap_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        int         period;
        logic       stop;
        int         gap;
        int         exp_rcv;
        int         exp_ferr;
        logic [7:0] exp_data;
        int         exp_div;
        logic       exp_lock;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame, starting and ending on a falling clock edge.
    // abort_kind 1: pulse relock in the middle of data bit abort_bit.
    // abort_kind 2: assert nRst in the middle of that bit and return at once.
    task automatic send_frame(input logic [7:0] d, input int p, input logic stop,
                              input int abort_bit, input int abort_kind);
        logic val;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      val = 1'b0;
            else if (b == 9) val = stop;
            else             val = d[b-1];
            rx = val;
            if (abort_kind != 0 && b - 1 == abort_bit) begin
                repeat (p / 2) @(negedge clk);
                if (abort_kind == 1) begin
                    relock = 1'b1;
                    @(negedge clk);
                    relock = 1'b0;
                    repeat (p - p / 2 - 1) @(negedge clk);
                end else begin
                    check("busy_before_reset", {31'b0, busy_rx}, 32'd1);
                    nRst = 1'b0;
                    rx = 1'b1;
                    return;
                end
            end else begin
                repeat (p) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        int r0;
        int f0;
        for (int i = lo; i <= hi; i++) begin
            repeat (vecs[i].gap) @(negedge clk);
            r0 = rcv_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].period, vecs[i].stop, -1, 0);
            check($sformatf("row%0d_rcv", i),  32'(rcv_cnt - r0),  32'(vecs[i].exp_rcv));
            check($sformatf("row%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("row%0d_data", i), {24'b0, data_rx}, {24'b0, vecs[i].exp_data});
            check($sformatf("row%0d_div", i),  {16'b0, baud_div}, 32'(vecs[i].exp_div));
            check($sformatf("row%0d_lock", i), {31'b0, baud_locked}, {31'b0, vecs[i].exp_lock});
            $display("[TB] row %0d: byte 0x%02h @%0d clk/bit -> data_rx=0x%02h baud_div=%0d locked=%0b",
                     i, vecs[i].data, vecs[i].period, data_rx, baud_div, baud_locked);
        end
    endtask

    initial begin
        int r0;
        int f0;
        // data, period, stop, gap, exp_rcv, exp_ferr, exp_data, exp_div, exp_lock
        vecs[0]  = '{8'h55, 100, 1'b1, 10, 0, 0, 8'h00, 100, 1'b1};
        vecs[1]  = '{8'h5A, 100, 1'b1,  0, 1, 0, 8'h5A, 100, 1'b1};
        vecs[2]  = '{8'h55, 434, 1'b1, 10, 0, 0, 8'h5A, 434, 1'b1};
        vecs[3]  = '{8'h01, 434, 1'b1,  0, 1, 0, 8'h01, 434, 1'b1};
        vecs[4]  = '{8'h00, 434, 1'b1,  0, 1, 0, 8'h00, 434, 1'b1};
        vecs[5]  = '{8'h03, 434, 1'b1,  0, 1, 0, 8'h03, 434, 1'b1};
        vecs[6]  = '{8'hFF, 434, 1'b1,  0, 1, 0, 8'hFF, 434, 1'b1};
        vecs[7]  = '{8'hA5, 434, 1'b0, 10, 0, 1, 8'hFF, 434, 1'b1};
        vecs[8]  = '{8'h3C, 434, 1'b1, 20, 1, 0, 8'h3C, 434, 1'b1};
        vecs[9]  = '{8'h55, 868, 1'b1, 10, 0, 0, 8'h3C, 868, 1'b1};
        vecs[10] = '{8'h02, 868, 1'b1,  0, 1, 0, 8'h02, 868, 1'b1};
        vecs[11] = '{8'h55, 434, 1'b1, 10, 0, 0, 8'h00, 434, 1'b1};
        vecs[12] = '{8'h81, 434, 1'b1,  0, 1, 0, 8'h81, 434, 1'b1};

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset_recieved", {31'b0, recieved},    32'd0);
        check("reset_ferr",     {31'b0, framing_err}, 32'd0);
        check("reset_busy",     {31'b0, busy_rx},     32'd0);
        check("reset_lock",     {31'b0, baud_locked}, 32'd0);
        check("reset_div",      {16'b0, baud_div},    32'd0);
        check("reset_data",     {24'b0, data_rx},     32'd0);
        nRst = 1'b1;
        repeat (5) @(negedge clk);
        $display("[TB] reset released");

        // A 3-cycle glitch while unlocked must not calibrate.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_lock", {31'b0, baud_locked}, 32'd0);
        check("glitch_div",  {16'b0, baud_div},    32'd0);
        $display("[TB] glitch: baud_locked=%0b baud_div=%0d", baud_locked, baud_div);

        run_rows(0, 1);

        // relock while idle drops the lock but keeps the old divider.
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        @(negedge clk);
        check("relock_idle_lock", {31'b0, baud_locked}, 32'd0);
        check("relock_idle_div",  {16'b0, baud_div},    32'd100);
        $display("[TB] relock idle: baud_locked=%0b baud_div=%0d", baud_locked, baud_div);

        run_rows(2, 6);

        // A 150-cycle low pulse is a false start at 434 clk/bit.
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (150) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("false_start_rcv",  32'(rcv_cnt - r0),  32'd0);
        check("false_start_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("false_start_busy", {31'b0, busy_rx},   32'd0);
        $display("[TB] false start: busy_rx=%0b", busy_rx);

        run_rows(7, 8);

        // relock in the middle of the data bits: no pulses, lock dropped.
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        send_frame(8'hF0, 434, 1'b1, 4, 1);
        repeat (10) @(negedge clk);
        check("relock_frame_rcv",  32'(rcv_cnt - r0),    32'd0);
        check("relock_frame_ferr", 32'(ferr_cnt - f0),   32'd0);
        check("relock_frame_lock", {31'b0, baud_locked}, 32'd0);
        check("relock_frame_div",  {16'b0, baud_div},    32'd434);
        $display("[TB] relock mid-frame: baud_locked=%0b baud_div=%0d", baud_locked, baud_div);

        run_rows(9, 10);

        // Reset in the middle of the data bits: outputs clear at once.
        send_frame(8'hF0, 868, 1'b1, 4, 2);
        #1;
        check("midrst_recieved", {31'b0, recieved},    32'd0);
        check("midrst_ferr",     {31'b0, framing_err}, 32'd0);
        check("midrst_busy",     {31'b0, busy_rx},     32'd0);
        check("midrst_lock",     {31'b0, baud_locked}, 32'd0);
        check("midrst_div",      {16'b0, baud_div},    32'd0);
        check("midrst_data",     {24'b0, data_rx},     32'd0);
        $display("[TB] reset mid-frame: data_rx=0x%02h baud_div=%0d", data_rx, baud_div);
        @(negedge clk);
        nRst = 1'b1;
        repeat (10) @(negedge clk);

        run_rows(11, 12);

        check("never_both_pulses", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
